lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the 2048x32 block RAM.
- Takes one CPU load/store request at a time: byte, halfword or word; signed or unsigned; any byte alignment.
- Converts each request into one or two BRAM word accesses, building byte-lane write masks and data on stores, and extracting and extending read data on loads.
- Accesses that cross a word boundary are split into two sequential BRAM accesses.

Parameters:
ADDR_W, 13, byte-address width; matches the BRAM address port.

Ports:
clk            input   1       clock
rst            input   1       synchronous reset, active-high
req_valid      input   1       request present
req_ready      output  1       unit can accept a request
req_we         input   1       1 = store, 0 = load
req_addr       input   ADDR_W  byte address
req_size       input   2       0 = byte, 1 = half, 2 = word, 3 = treated as word
req_unsigned   input   1       loads only: zero-extend instead of sign-extend
req_wdata      input   32      store data, right-aligned
resp_valid     output  1       one-cycle completion pulse
resp_rdata     output  32      load result; 0 for stores
mem_rd_en      output  1       BRAM read strobe
mem_addr       output  ADDR_W  BRAM byte address, always word-aligned (addr[1:0] = 0)
mem_rd_data    input   32      BRAM read data
mem_rd_valid   input   1       BRAM read data valid; arrives the cycle after mem_rd_en
mem_wr_en      output  1       BRAM write strobe
mem_wr_data    output  32      BRAM write data
mem_wr_mask    output  4       byte enables; bit 3 = bits[7:0], bit 2 = [15:8], bit 1 = [23:16], bit 0 = [31:24]

Behaviour:
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- Reset values: state IDLE. req_ready, resp_valid, mem_rd_en and mem_wr_en are 0. resp_rdata, mem_addr, mem_wr_data and mem_wr_mask are 0.
- req_ready = (state == IDLE) && !rst.
- Acceptance: a request is accepted on req_valid && req_ready. On acceptance, latch all req_* fields and go to ISSUE1.
- Path isolation: all mem_* outputs are decoded from the state register and latched fields only. There is no combinational path from req_* to mem_*.
- Lane math:
  - o = addr[1:0]; n = 1, 2 or 4 bytes.
  - Byte lanes o..o+n-1 are occupied.
  - split = (o + n > 4).
  - word0 = {addr[ADDR_W-1:2], 2'b00}.
  - word1 = word0 + 4, modulo 2^ADDR_W (wraps to 0).
- Store data and masks:
  - 64-bit value S = req_wdata (low n bytes) << 8*o.
  - Access 1 writes S[31:0]; access 2 writes S[63:32].
  - Lane L (0..3) of each word maps to mask bit 3-L. The mask bit is set only for occupied lanes.
- Load assembly:
  - D = {data1, data0}, where data1 = 0 if not split.
  - Result = low n bytes of (D >> 8*o), then sign- or zero-extended to 32 bits per req_unsigned.
- ISSUE1: assert mem_addr = word0, plus mem_rd_en (load) or mem_wr_en with mask/data (store). Next state:
  - load → WAIT1;
  - store, split → ISSUE2;
  - store, not split → DONE.
- WAIT1: hold until mem_rd_valid, then capture data0. Next: split → ISSUE2, else → DONE.
- ISSUE2: same as ISSUE1 using word1 and upper lanes. Next: load → WAIT2, store → DONE.
- WAIT2: on mem_rd_valid, capture data1 → DONE.
- DONE: resp_valid = 1 for exactly one cycle and resp_rdata updated; then → IDLE. resp_rdata holds its value until the next DONE.
- Latency (acceptance at cycle N):
  - aligned store: write N+1, resp N+2;
  - aligned load: rd_en N+1, resp N+3;
  - split store: writes N+1 and N+2, resp N+3;
  - split load: rd_en N+1 and N+3, resp N+5.
  - Peak rate is one request per 3 cycles (aligned store: IDLE→ISSUE1→DONE→IDLE).
- Ignored inputs:
  - mem_rd_valid outside WAIT1/WAIT2 is ignored.
  - req_* changes while not in IDLE are ignored; a held req_valid is accepted on return to IDLE.
- Reset mid-operation: return to IDLE next cycle and issue no further mem accesses. No resp_valid is generated for the aborted request. A split store that completed its first write leaves that write in memory; this partial store is accepted behaviour.

Test Plan:
1. Store word 0x11223344 at 0x100 → N+1: mem_wr_en, mem_addr 0x100, mask 4'b1111, wr_data 0x11223344; resp_valid at N+2. Then load word 0x100 → rd_en at N+1, resp_rdata 0x11223344 at N+3.
2. Store byte 0xAB at 0x103 → mask 4'b0001, wr_data[31:24] = 0xAB. Signed byte load 0x103 → 0xFFFFFFAB; unsigned → 0x000000AB; signed byte load 0x100 → 0x00000044.
3. Store word 0xDEADBEEF at 0x0FE → write 0x0FC mask 4'b0011 with [31:16] = 0xBEEF, then write 0x100 mask 4'b1100 with [15:0] = 0xDEAD, resp N+3. Load word 0x0FE → 0xDEADBEEF with resp at N+5.
4. Signed half load at 0x1FFF, with mem 0x1FFC = 0x80000000 and 0x0000 = 0x000000FF → reads 0x1FFC then 0x0000 (wrap); result 0xFFFFFF80.
5. Assert rst during WAIT1 of a load → no resp_valid; mem_rd_en stays 0; req_ready = 1 on the first cycle after rst deasserts.
6. Hold req_valid high across 3 back-to-back aligned stores → one acceptance every 3 cycles; each produces exactly one mem_wr_en and one resp_valid pulse.

Source files
------------

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit splitting CPU byte/half/word accesses into BRAM word accesses
module lsu_mem_port #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_wr_mask
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data0_q;
  logic [31:0]       data1_q;

  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic              split;
  logic [7:0]        lane_fill;
  logic [31:0]       wdata_trim;
  logic [63:0]       st_wide;
  logic [ADDR_W-1:0] word0;
  logic [ADDR_W-1:0] word1;
  logic [3:0]        mask0;
  logic [3:0]        mask1;

  logic [31:0]       ld_d0;
  logic [31:0]       ld_d1;
  logic [63:0]       ld_wide;
  logic [31:0]       ld_al;
  logic [31:0]       ld_res;

  assign off   = addr_q[1:0];
  assign word0 = {addr_q[ADDR_W-1:2], 2'b00};
  assign word1 = word0 + ADDR_W'(4);
  assign split = ({1'b0, off} + nbytes) > 3'd4;

  always_comb begin
    nbytes     = 3'd4;
    lane_fill  = 8'h0f;
    wdata_trim = wdata_q;
    case (size_q)
      2'd0: begin
        nbytes     = 3'd1;
        lane_fill  = 8'h01;
        wdata_trim = {24'b0, wdata_q[7:0]};
      end
      2'd1: begin
        nbytes     = 3'd2;
        lane_fill  = 8'h03;
        wdata_trim = {16'b0, wdata_q[15:0]};
      end
      default: begin
        nbytes     = 3'd4;
        lane_fill  = 8'h0f;
        wdata_trim = wdata_q;
      end
    endcase
    lane_fill = lane_fill << off;
  end

  assign st_wide = {32'b0, wdata_trim} << {off, 3'b000};

  // Lane 0 (bits 7:0) is reported on mask bit 3, so each nibble is bit-reversed.
  assign mask0 = {lane_fill[0], lane_fill[1], lane_fill[2], lane_fill[3]};
  assign mask1 = {lane_fill[4], lane_fill[5], lane_fill[6], lane_fill[7]};

  // Read data arriving this cycle is folded in so the result registers on entry to DONE.
  assign ld_d0   = (state == WAIT1) ? mem_rd_data : data0_q;
  assign ld_d1   = (state == WAIT2) ? mem_rd_data : data1_q;
  assign ld_wide = {ld_d1, ld_d0};
  assign ld_al   = 32'(ld_wide >> {off, 3'b000});

  always_comb begin
    ld_res = ld_al;
    case (size_q)
      2'd0:    ld_res = uns_q ? {24'b0, ld_al[7:0]} : {{24{ld_al[7]}}, ld_al[7:0]};
      2'd1:    ld_res = uns_q ? {16'b0, ld_al[15:0]} : {{16{ld_al[15]}}, ld_al[15:0]};
      default: ld_res = ld_al;
    endcase
  end

  always_comb begin
    state_nx    = state;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = 32'b0;
    mem_wr_mask = 4'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nx = ISSUE1;
      end
      ISSUE1: begin
        mem_addr = word0;
        if (we_q) begin
          mem_wr_en   = 1'b1;
          mem_wr_mask = mask0;
          mem_wr_data = st_wide[31:0];
          state_nx    = split ? ISSUE2 : DONE;
        end else begin
          mem_rd_en = 1'b1;
          state_nx  = WAIT1;
        end
      end
      WAIT1: begin
        if (mem_rd_valid) state_nx = split ? ISSUE2 : DONE;
      end
      ISSUE2: begin
        mem_addr = word1;
        if (we_q) begin
          mem_wr_en   = 1'b1;
          mem_wr_mask = mask1;
          mem_wr_data = st_wide[63:32];
          state_nx    = DONE;
        end else begin
          mem_rd_en = 1'b1;
          state_nx  = WAIT2;
        end
      end
      WAIT2: begin
        if (mem_rd_valid) state_nx = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset squashes any access that the current state would otherwise issue.
    if (rst) begin
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = 32'b0;
      mem_wr_mask = 4'b0;
      resp_valid  = 1'b0;
    end
  end

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      wdata_q    <= 32'b0;
      data0_q    <= 32'b0;
      data1_q    <= 32'b0;
      resp_rdata <= 32'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        data0_q <= 32'b0;
        data1_q <= 32'b0;
      end
      if (state == WAIT1 && mem_rd_valid) data0_q <= mem_rd_data;
      if (state == WAIT2 && mem_rd_valid) data1_q <= mem_rd_data;
      if (state_nx == DONE && state != DONE) resp_rdata <= we_q ? 32'b0 : ld_res;
    end
  end

endmodule
